// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth sequential multiplier:
// FSM state encoding, partial-product selector and the Booth digit decoder.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } booth_sel_e;

  // Map the overlapping 3-bit group {Q[1],Q[0],q_m1} to a multiple of M.
  function automatic booth_sel_e booth_decode(input logic [2:0] code);
    booth_sel_e sel;
    case (code)
      3'b001, 3'b010: sel = POS1;
      3'b011:         sel = POS2;
      3'b100:         sel = NEG2;
      3'b101, 3'b110: sel = NEG1;
      default:        sel = ZERO;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-4 Booth step: add 0/+-M/+-2M into the accumulator, then shift
// {A,Q,q_m1} right by two with A's sign replicated. Purely combinational.
// Only Q[DATA_W-1:1] is needed here: Q[0] only feeds the code, which the
// caller builds.
module booth_step
  import booth_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W+1:0] i_a,
  input  logic [DATA_W+1:0] i_m,
  input  logic [DATA_W-1:1] i_q_hi,
  input  logic [2:0]        i_code,
  output logic [DATA_W+1:0] o_a,
  output logic [DATA_W-1:0] o_q,
  output logic              o_q_m1
);

  logic [DATA_W+1:0] w_addend;
  logic              w_cin;
  logic [DATA_W+1:0] w_sum;

  // Select the partial product; negation is one's complement plus carry-in.
  always_comb begin
    w_addend = '0;
    w_cin    = 1'b0;
    case (booth_decode(i_code))
      POS1: w_addend = i_m;
      POS2: w_addend = {i_m[DATA_W:0], 1'b0};
      NEG1: begin
        w_addend = ~i_m;
        w_cin    = 1'b1;
      end
      NEG2: begin
        w_addend = ~{i_m[DATA_W:0], 1'b0};
        w_cin    = 1'b1;
      end
      default: begin
        w_addend = '0;
        w_cin    = 1'b0;
      end
    endcase
  end

  // DATA_W+2 bits hold any intermediate sum of a 2M-bounded Booth sequence.
  assign w_sum  = i_a + w_addend + {{(DATA_W+1){1'b0}}, w_cin};
  assign o_a    = {{2{w_sum[DATA_W+1]}}, w_sum[DATA_W+1:2]};
  assign o_q    = {w_sum[1:0], i_q_hi[DATA_W-1:2]};
  assign o_q_m1 = i_q_hi[1];

endmodule

// File: rtl/booth_r4_seq_mul.sv
// Sequential signed radix-4 Booth multiplier, DATA_W x DATA_W -> 2*DATA_W.
// One Booth digit per cycle, valid/ready on both sides.
// Optional build macro BOOTH_ZERO_SKIP_EN: a zero operand bypasses the
// iterations and lands directly in DONE with a zero product.
module booth_r4_seq_mul
  import booth_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_W-1:0]     mcand_i,
  input  logic [DATA_W-1:0]     mplier_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [2*DATA_W-1:0]   product_o
);

  localparam int ITER  = DATA_W / 2;
  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

  state_e              r_state;
  state_e              w_state_next;
  logic [DATA_W+1:0]   r_a, w_a_next;
  logic [DATA_W+1:0]   r_m, w_m_next;
  logic [DATA_W-1:0]   r_q, w_q_next;
  logic                r_q_m1, w_q_m1_next;
  logic [CNT_W-1:0]    r_cnt, w_cnt_next;

  logic [DATA_W+1:0]   w_step_a;
  logic [DATA_W-1:0]   w_step_q;
  logic                w_step_q_m1;

  booth_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .i_a    (r_a),
    .i_m    (r_m),
    .i_q_hi (r_q[DATA_W-1:1]),
    .i_code ({r_q[1:0], r_q_m1}),
    .o_a    (w_step_a),
    .o_q    (w_step_q),
    .o_q_m1 (w_step_q_m1)
  );

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath registers; cleared so product_o reads zero out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_a    <= '0;
      r_m    <= '0;
      r_q    <= '0;
      r_q_m1 <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_a    <= w_a_next;
      r_m    <= w_m_next;
      r_q    <= w_q_next;
      r_q_m1 <= w_q_m1_next;
      r_cnt  <= w_cnt_next;
    end
  end

  // Next-state, datapath load/step and handshake outputs.
  always_comb begin
    w_state_next = r_state;
    w_a_next     = r_a;
    w_m_next     = r_m;
    w_q_next     = r_q;
    w_q_m1_next  = r_q_m1;
    w_cnt_next   = r_cnt;
    ready_o      = 1'b0;
    valid_o      = 1'b0;
    case (r_state)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) begin
          w_m_next     = {{2{mcand_i[DATA_W-1]}}, mcand_i};
          w_a_next     = '0;
          w_q_next     = mplier_i;
          w_q_m1_next  = 1'b0;
          w_cnt_next   = '0;
          w_state_next = CALC;
`ifdef BOOTH_ZERO_SKIP_EN
          if ((mcand_i == '0) || (mplier_i == '0)) begin
            w_q_next     = '0;
            w_state_next = DONE;
          end
`endif
        end
      end
      CALC: begin
        w_a_next    = w_step_a;
        w_q_next    = w_step_q;
        w_q_m1_next = w_step_q_m1;
        w_cnt_next  = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(ITER - 1)) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        valid_o = 1'b1;
        if (ready_i) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // After ITER double shifts the full product sits in A's low half and Q.
  assign product_o = {r_a[DATA_W-1:0], r_q};

endmodule
